// File: rtl/bloque_fecha_calendario_if.sv
// Signal bundle between the BCD calendar date block and its neighbours
// (RTC read path, menu selector, buttons, RTC write handshake, display path).
interface bloque_fecha_calendario_if;
    logic [7:0] IN_diaf;
    logic [7:0] IN_mesf;
    logic [7:0] IN_anof;
    logic       READ;
    logic [3:0] Selec_Demux_DD;
    logic [3:0] IN_bot_fecha;
    logic       WR_ack;
    logic [7:0] OUT_diaf;
    logic [7:0] OUT_mesf;
    logic [7:0] OUT_anof;
    logic [1:0] Contador_pos_f;
    logic       WR_req;
    logic       BCD_err;
    logic       WR_err;

    modport master (
        output IN_diaf, IN_mesf, IN_anof, READ, Selec_Demux_DD, IN_bot_fecha, WR_ack,
        input  OUT_diaf, OUT_mesf, OUT_anof, Contador_pos_f, WR_req, BCD_err, WR_err
    );

    modport slave (
        input  IN_diaf, IN_mesf, IN_anof, READ, Selec_Demux_DD, IN_bot_fecha, WR_ack,
        output OUT_diaf, OUT_mesf, OUT_anof, Contador_pos_f, WR_req, BCD_err, WR_err
    );
endinterface

// File: rtl/bloque_fecha_calendario.sv
// BCD calendar date holder: follows RTC reads, allows cursor editing with
// leap-aware day limits and button auto-repeat, then writes back over req/ack.
module bloque_fecha_calendario #(
    parameter logic [3:0] SEL_EDIT    = 4'd4,
    parameter int         REP_RETARDO = 25,
    parameter int         REP_PERIODO = 10,
    parameter int         WR_TIMEOUT  = 255,
    parameter logic [7:0] INI_DIA     = 8'h01,
    parameter logic [7:0] INI_MES     = 8'h01,
    parameter logic [7:0] INI_ANO     = 8'h00
) (
    input logic                     reloj,
    input logic                     resetM,
    bloque_fecha_calendario_if.slave bus
);

    localparam int REP_MAX = (REP_RETARDO > REP_PERIODO) ? REP_RETARDO : REP_PERIODO;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int TO_W    = $clog2(WR_TIMEOUT + 1);

    typedef enum logic [1:0] {SEGUIR, EDICION, ESCRITURA} estado_t;

    estado_t          estado_q, estado_d;
    logic [7:0]       dia_q, dia_d;
    logic [7:0]       mes_q, mes_d;
    logic [7:0]       ano_q, ano_d;
    logic [1:0]       pos_q, pos_d;
    logic             req_q, req_d;
    logic             bcd_err_q, bcd_err_d;
    logic             wr_err_q, wr_err_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_fase_q, rep_fase_d;
    logic             armado_q, armado_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]       bot_prev_q;

    logic             accion;
    logic             sube;
    logic [6:0]       dia_b, mes_b, ano_b;
    logic [6:0]       ndia_b, nmes_b, nano_b;

    function automatic logic [6:0] bcd2bin(input logic [7:0] b);
        return {3'b000, b[7:4]} * 7'd10 + {3'b000, b[3:0]};
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        return (8'(v / 7'd10) << 4) | 8'(v % 7'd10);
    endfunction

    function automatic logic bcd_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    // Years are 2000-2099, so divisibility by 4 alone decides February.
    function automatic logic [6:0] max_dia(input logic [6:0] mes, input logic [6:0] ano);
        case (mes)
            7'd4, 7'd6, 7'd9, 7'd11: return 7'd30;
            7'd2:                    return ((ano % 7'd4) == 7'd0) ? 7'd29 : 7'd28;
            default:                 return 7'd31;
        endcase
    endfunction

    function automatic logic fecha_valida(input logic [7:0] d, input logic [7:0] m,
                                          input logic [7:0] a);
        logic [6:0] db, mb;
        db = bcd2bin(d);
        mb = bcd2bin(m);
        if (!(bcd_ok(d) && bcd_ok(m) && bcd_ok(a))) return 1'b0;
        if (mb < 7'd1 || mb > 7'd12) return 1'b0;
        return (db >= 7'd1) && (db <= max_dia(mb, bcd2bin(a)));
    endfunction

    function automatic logic [6:0] paso(input logic [6:0] v, input logic [6:0] lo,
                                        input logic [6:0] hi, input logic arriba);
        if (arriba) return (v >= hi) ? lo : v + 7'd1;
        return (v <= lo) ? hi : v - 7'd1;
    endfunction

    function automatic logic [6:0] limita(input logic [6:0] v, input logic [6:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    always_comb begin
        estado_d   = estado_q;
        dia_d      = dia_q;
        mes_d      = mes_q;
        ano_d      = ano_q;
        pos_d      = pos_q;
        req_d      = req_q;
        bcd_err_d  = 1'b0;
        wr_err_d   = 1'b0;
        rep_cnt_d  = rep_cnt_q;
        rep_fase_d = rep_fase_q;
        armado_d   = armado_q;
        to_cnt_d   = to_cnt_q;
        accion     = 1'b0;
        sube       = 1'b0;
        dia_b      = bcd2bin(dia_q);
        mes_b      = bcd2bin(mes_q);
        ano_b      = bcd2bin(ano_q);
        ndia_b     = dia_b;
        nmes_b     = mes_b;
        nano_b     = ano_b;

        case (estado_q)
            SEGUIR: begin
                rep_cnt_d  = '0;
                rep_fase_d = 1'b0;
                armado_d   = 1'b0;
                if (bus.Selec_Demux_DD == SEL_EDIT) begin
                    estado_d = EDICION;
                end else if (bus.READ) begin
                    if (fecha_valida(bus.IN_diaf, bus.IN_mesf, bus.IN_anof)) begin
                        dia_d = bus.IN_diaf;
                        mes_d = bus.IN_mesf;
                        ano_d = bus.IN_anof;
                    end else begin
                        bcd_err_d = 1'b1;
                    end
                end
            end

            EDICION: begin
                if (bus.Selec_Demux_DD != SEL_EDIT) begin
                    estado_d   = ESCRITURA;
                    req_d      = 1'b1;
                    pos_d      = 2'd0;
                    to_cnt_d   = '0;
                    rep_cnt_d  = '0;
                    rep_fase_d = 1'b0;
                    armado_d   = 1'b0;
                end else begin
                    // Repeat only continues an armed single-button press; anything else disarms.
                    if (!$onehot(bus.IN_bot_fecha)) begin
                        rep_cnt_d  = '0;
                        rep_fase_d = 1'b0;
                        armado_d   = 1'b0;
                    end else if (bot_prev_q == 4'b0000) begin
                        accion     = 1'b1;
                        rep_cnt_d  = REP_W'(1);
                        rep_fase_d = 1'b0;
                        armado_d   = 1'b1;
                    end else if (armado_q && (bus.IN_bot_fecha == bot_prev_q)) begin
                        if (!rep_fase_q) begin
                            if (rep_cnt_q == REP_W'(REP_RETARDO)) begin
                                accion     = 1'b1;
                                rep_cnt_d  = REP_W'(1);
                                rep_fase_d = 1'b1;
                            end else begin
                                rep_cnt_d = rep_cnt_q + REP_W'(1);
                            end
                        end else if (rep_cnt_q == REP_W'(REP_PERIODO)) begin
                            accion    = 1'b1;
                            rep_cnt_d = REP_W'(1);
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_W'(1);
                        end
                    end else begin
                        rep_cnt_d  = '0;
                        rep_fase_d = 1'b0;
                        armado_d   = 1'b0;
                    end

                    if (accion) begin
                        case (bus.IN_bot_fecha)
                            4'b0010: pos_d = (pos_q == 2'd2) ? 2'd0 : pos_q + 2'd1;
                            4'b0001: pos_d = (pos_q == 2'd0) ? 2'd2 : pos_q - 2'd1;
                            default: begin
                                sube = bus.IN_bot_fecha[3];
                                case (pos_q)
                                    2'd0: ndia_b = paso(dia_b, 7'd1, max_dia(mes_b, ano_b), sube);
                                    2'd1: begin
                                        nmes_b = paso(mes_b, 7'd1, 7'd12, sube);
                                        ndia_b = limita(dia_b, max_dia(nmes_b, ano_b));
                                    end
                                    default: begin
                                        nano_b = paso(ano_b, 7'd0, 7'd99, sube);
                                        ndia_b = limita(dia_b, max_dia(mes_b, nano_b));
                                    end
                                endcase
                                dia_d = bin2bcd(ndia_b);
                                mes_d = bin2bcd(nmes_b);
                                ano_d = bin2bcd(nano_b);
                            end
                        endcase
                    end
                end
            end

            ESCRITURA: begin
                // Ack wins over a timeout landing on the same edge.
                if (bus.WR_ack) begin
                    req_d    = 1'b0;
                    estado_d = SEGUIR;
                end else if (to_cnt_q == TO_W'(WR_TIMEOUT - 1)) begin
                    req_d    = 1'b0;
                    wr_err_d = 1'b1;
                    estado_d = SEGUIR;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            default: estado_d = SEGUIR;
        endcase
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            estado_q   <= SEGUIR;
            dia_q      <= INI_DIA;
            mes_q      <= INI_MES;
            ano_q      <= INI_ANO;
            pos_q      <= 2'd0;
            req_q      <= 1'b0;
            bcd_err_q  <= 1'b0;
            wr_err_q   <= 1'b0;
            rep_cnt_q  <= '0;
            rep_fase_q <= 1'b0;
            armado_q   <= 1'b0;
            to_cnt_q   <= '0;
            bot_prev_q <= 4'b0000;
        end else begin
            estado_q   <= estado_d;
            dia_q      <= dia_d;
            mes_q      <= mes_d;
            ano_q      <= ano_d;
            pos_q      <= pos_d;
            req_q      <= req_d;
            bcd_err_q  <= bcd_err_d;
            wr_err_q   <= wr_err_d;
            rep_cnt_q  <= rep_cnt_d;
            rep_fase_q <= rep_fase_d;
            armado_q   <= armado_d;
            to_cnt_q   <= to_cnt_d;
            bot_prev_q <= bus.IN_bot_fecha;
        end
    end

    assign bus.OUT_diaf       = dia_q;
    assign bus.OUT_mesf       = mes_q;
    assign bus.OUT_anof       = ano_q;
    assign bus.Contador_pos_f = pos_q;
    assign bus.WR_req         = req_q;
    assign bus.BCD_err        = bcd_err_q;
    assign bus.WR_err         = wr_err_q;

endmodule
